// File: rtl/pio_in_pkg.sv
// Shared constants for the debounced switch/button PIO: register word addresses,
// edge-type encodings and the debounce counter width helper.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must hold 0..DEBOUNCE_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_in_debounce_bit.sv
// One input bit: multi-flop synchroniser followed by a hold-time debouncer.
// With PIO_IN_DEBOUNCE_EN undefined the debouncer collapses to a single register.
module pio_in_debounce_bit
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("pio_in_debounce_bit: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= 1'b0;
    else          stable <= sync;
  end
`endif

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Avalon-MM input PIO with per-bit sync/debounce, edge capture and masked level irq.
// Debounce counters are present only when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_debounce_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wd;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_in_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[g]),
      .stable  (stable[g])
    );
  end

  assign wr_en     = chipselect && !write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    edge_set = stable & ~prev;
    if (EDGE_TYPE == EDGE_FALL)     edge_set = ~stable & prev;
    else if (EDGE_TYPE == EDGE_ANY) edge_set = stable ^ prev;
  end

  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = 32'(stable);
      ADDR_IRQMASK: rd_mux = 32'(irqmask);
      ADDR_EDGE:    rd_mux = 32'(edgecapture);
      default:      rd_mux = '0;
    endcase
  end

  // A set pulse outranks a W1C of the same bit in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      prev        <= stable;
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      readdata    <= rd_mux;
      irq         <= |(edgecapture & irqmask);
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Scoreboard bench for pio_in_debounce_irq: tasks queue expected read/irq values,
// a negedge monitor pops and compares them. Latency adapts to PIO_IN_DEBOUNCE_EN.
module tb_pio_in_debounce_irq;

  localparam int WIDTH = 10;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int          LAT        = SYNC + DEB;
  localparam logic [31:0] GLITCH_EXP = 32'h0;
`else
  localparam int          LAT        = SYNC + 1;
  localparam logic [31:0] GLITCH_EXP = 32'h8;
`endif

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  pio_in_debounce_irq #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .EDGE_TYPE       (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit 32 of a queue entry selects irq (1) or readdata (0).
  logic [32:0] exp_q[$];
  string       name_q[$];
  bit          rd_req    = 1'b0;
  bit          rd_vld    = 1'b0;
  bit          now_req   = 1'b0;
  bit          final_req = 1'b0;
  int          total     = 0;
  int          bad       = 0;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] act;
    string       n;
    if (rd_vld || now_req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: no expectation queued, readdata=%h irq=%b", readdata, irq);
      end else begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = e[32] ? {31'd0, irq} : readdata;
        if (act !== e[31:0]) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, act, e[31:0]);
        end
      end
    end
    if (final_req) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    exp_q.push_back({1'b0, e});
    name_q.push_back(n);
    rd_req = 1'b1;
    tick(1);
    rd_req     = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string n);
    exp_q.push_back({1'b1, 31'd0, e});
    name_q.push_back(n);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    in_port    = 10'h3FF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick(3);

    // In reset, then release with all pins already high.
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd3, 32'h0, "rst_edge");
    chk_irq(1'b0, "rst_irq");
    reset_n = 1'b1;
    rd(2'd0, 32'h0, "data_early");
    tick(LAT - 2);
    rd(2'd0, 32'h0,   "data_before_lat");
    rd(2'd0, 32'h3FF, "data_after_lat");
    rd(2'd3, 32'h3FF, "edge_after_rst");
    chk_irq(1'b0, "irq_unmasked_none");
    wr(2'd3, 32'h3FF);
    rd(2'd3, 32'h0, "edge_cleared");

    // Falling edges are not captured.
    in_port = '0;
    tick(LAT + 2);
    rd(2'd0, 32'h0, "data_low");
    rd(2'd3, 32'h0, "no_fall_capture");

    // Three-cycle glitch on bit 3.
    in_port[3] = 1'b1;
    tick(3);
    in_port[3] = 1'b0;
    tick(LAT + 3);
    rd(2'd0, 32'h0,     "glitch_data");
    rd(2'd3, GLITCH_EXP, "glitch_edge");
    wr(2'd3, 32'h3FF);

    // Debounced rising edge on bit 3 with irq enabled.
    wr(2'd2, 32'h008);
    in_port[3] = 1'b1;
    tick(LAT - 1);
    rd(2'd0, 32'h0, "b3_before_lat");
    chk_irq(1'b0, "b3_irq_not_yet");
    chk_irq(1'b1, "b3_irq_set");
    rd(2'd0, 32'h008, "b3_data");
    rd(2'd3, 32'h008, "b3_edge");
    wr(2'd3, 32'h008);
    chk_irq(1'b0, "b3_irq_cleared");
    rd(2'd3, 32'h0,   "b3_edge_cleared");
    rd(2'd0, 32'h008, "b3_data_held");

    // Masked edge on bit 0, then unmask.
    wr(2'd2, 32'h0);
    in_port[0] = 1'b1;
    tick(LAT + 3);
    rd(2'd3, 32'h001, "b0_edge");
    chk_irq(1'b0, "b0_irq_masked");
    wr(2'd2, 32'h001);
    chk_irq(1'b1, "b0_irq_unmasked");
    wr(2'd3, 32'h3FF);
    wr(2'd2, 32'h0);

    // W1C of bit 5 lands on the same edge as its set pulse.
    in_port[5] = 1'b1;
    tick(LAT);
    wr(2'd3, 32'h020);
    rd(2'd3, 32'h020, "collision_set_wins");
    rd(2'd0, 32'h029, "data_029");

    // Reserved word and upper bits.
    rd(2'd1, 32'h0, "reserved");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "reserved_after_wr");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h3FF, "mask_upper");
    chk_irq(1'b1, "irq_bit5");
    tick(1);

    // Reset with an interrupt pending drops irq without a clock edge.
    exp_q.push_back({1'b1, 32'h0});
    name_q.push_back("irq_async_reset");
    now_req = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    now_req = 1'b0;
    in_port = '0;
    tick(1);
    reset_n = 1'b1;
    rd(2'd2, 32'h0, "mask_after_rst");
    rd(2'd3, 32'h0, "edge_after_rst2");

    tick(2);
    final_req = 1'b1;
    @(negedge clk);
    #1;
    final_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
